// File: rtl/fdiv_prog_ctrl.sv
// Programmable divide-by-N controller: ratio changes over valid/ready, applied only at a counter wrap.
// Optional FDIV_CTRL_ERR_EN: drop requests below 2 and raise a sticky err flag (otherwise clamp to 2).
module fdiv_prog_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEF_RATIO = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [WIDTH-1:0] ratio_req,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [WIDTH-1:0] ratio_cur,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
`ifdef FDIV_CTRL_ERR_EN
    output logic             div_out,
    output logic             err
`else
    output logic             div_out
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(DEF_RATIO);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] ratio_reg, ratio_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             tc_reg, tc_next;
    logic             div_reg, div_next;

    logic             accept;
    logic             req_legal;
    logic             take;
    logic [WIDTH-1:0] req_val;
    logic             wrap;
    logic             running_next;

    assign accept    = req_valid && req_ready;
    assign req_legal = (ratio_req >= TWO);
    assign wrap      = (cnt_reg == ratio_reg - ONE);

`ifdef FDIV_CTRL_ERR_EN
    logic err_reg, err_next;

    // Illegal requests complete the handshake but never reach the ratio path.
    assign take     = accept && req_legal;
    assign req_val  = ratio_req;
    assign err_next = err_reg || (accept && !req_legal);
    assign err      = err_reg;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
`else
    assign take    = accept;
    assign req_val = req_legal ? ratio_req : TWO;
`endif

    always_comb begin
        state_next = state_reg;
        ratio_next = ratio_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (take) begin
                    ratio_next = req_val;
                end
                if (en) begin
                    state_next = RUN;
                    cnt_next   = ONE;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (take) begin
                        ratio_next = req_val;
                    end
                end else begin
                    cnt_next = wrap ? '0 : cnt_reg + ONE;
                    if (take) begin
                        // A request landing on the wrap cycle applies at once and skips PEND.
                        if (wrap) begin
                            ratio_next = req_val;
                        end else begin
                            pend_next  = req_val;
                            state_next = PEND;
                        end
                    end
                end
            end
            PEND: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    ratio_next = pend_reg;
                end else if (wrap) begin
                    state_next = RUN;
                    cnt_next   = '0;
                    ratio_next = pend_reg;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // tc and div_out are decoded from next-cycle values so they leave flops aligned with cnt.
    assign running_next = (state_next != IDLE);
    assign tc_next      = running_next && (cnt_next == ratio_next - ONE);
    assign div_next     = running_next && (cnt_next < (ratio_next >> 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg <= IDLE;
            ratio_reg <= RESET_RATIO;
            cnt_reg   <= '0;
            pend_reg  <= '0;
            tc_reg    <= 1'b0;
            div_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ratio_reg <= ratio_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            tc_reg    <= tc_next;
            div_reg   <= div_next;
        end
    end

    assign req_ready = (state_reg != PEND);
    assign ratio_cur = ratio_reg;
    assign cnt       = cnt_reg;
    assign tc        = tc_reg;
    assign div_out   = div_reg;

endmodule

// File: tb/tb_fdiv_prog_ctrl.sv
// Directed bench for fdiv_prog_ctrl: reset, steady division, mid-period and wrap-aligned changes,
// en drop while pending, illegal ratio and asynchronous reset.
module tb_fdiv_prog_ctrl;

    logic       clk;
    logic       rstb;
    logic       en;
    logic [7:0] ratio_req;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] ratio_cur;
    logic [7:0] cnt;
    logic       tc;
    logic       div_out;
`ifdef FDIV_CTRL_ERR_EN
    logic       err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fdiv_prog_ctrl #(.WIDTH(8), .DEF_RATIO(16)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .ratio_req (ratio_req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ratio_cur (ratio_cur),
        .cnt       (cnt),
        .tc        (tc),
`ifdef FDIV_CTRL_ERR_EN
        .div_out   (div_out),
        .err       (err)
`else
        .div_out   (div_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int e_ratio, input int e_cnt,
                           input int e_tc, input int e_div, input int e_rdy);
        $display("step %s: ratio_cur=%0d cnt=%0d tc=%0d div_out=%0d req_ready=%0d",
                 tag, ratio_cur, cnt, tc, div_out, req_ready);
        chk({tag, ".ratio_cur"}, 32'(ratio_cur), 32'(e_ratio));
        chk({tag, ".cnt"},       32'(cnt),       32'(e_cnt));
        chk({tag, ".tc"},        32'(tc),        32'(e_tc));
        chk({tag, ".div_out"},   32'(div_out),   32'(e_div));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(e_rdy));
    endtask

    initial begin
        rstb      = 1'b0;
        en        = 1'b0;
        ratio_req = 8'd0;
        req_valid = 1'b0;
        tick();
        tick();
        chk_all("reset", 16, 0, 0, 0, 1);
`ifdef FDIV_CTRL_ERR_EN
        chk("reset.err", 32'(err), 32'd0);
`endif

        // Release reset and enable: cnt=1 after the first edge, N=16 afterwards.
        rstb = 1'b1;
        en   = 1'b1;
        for (int i = 1; i <= 51; i++) begin
            tick();
            chk_all("run16", 16, i % 16, int'((i % 16) == 15), int'((i % 16) < 8), 1);
        end

        // Request N=5 while cnt=3: the 16-period must finish first.
        ratio_req = 8'd5;
        req_valid = 1'b1;
        for (int i = 52; i <= 63; i++) begin
            tick();
            req_valid = 1'b0;
            chk_all("pend16", 16, i - 48, int'((i - 48) == 15), int'((i - 48) < 8), 0);
        end
        for (int k = 0; k <= 14; k++) begin
            tick();
            chk_all("run5", 5, k % 5, int'((k % 5) == 4), int'((k % 5) < 2), 1);
        end

        // Request N=10 on the tc cycle of N=5: applied at that wrap, no PEND.
        ratio_req = 8'd10;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_all("wrap10", 10, 0, 0, 1, 1);
        for (int j = 1; j <= 9; j++) begin
            tick();
            chk_all("run10", 10, j, int'(j == 9), int'(j < 5), 1);
        end

        // Request N=4 on the tc cycle of N=10.
        ratio_req = 8'd4;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_all("wrap4", 4, 0, 0, 1, 1);
        for (int m = 1; m <= 8; m++) begin
            tick();
            chk_all("run4", 4, m % 4, int'((m % 4) == 3), int'((m % 4) < 2), 1);
        end

        // Pend N=7, then drop en: ratio must load on the way to IDLE.
        ratio_req = 8'd7;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_all("pend7", 4, 1, 0, 1, 0);
        en = 1'b0;
        tick();
        chk_all("idle7", 7, 0, 0, 0, 1);
        tick();
        chk_all("idle7b", 7, 0, 0, 0, 1);

        // Illegal ratio 1 requested while running at N=7.
        en = 1'b1;
        tick();
        chk_all("run7", 7, 1, 0, 1, 1);
        ratio_req = 8'd1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
`ifdef FDIV_CTRL_ERR_EN
        chk_all("illegal", 7, 2, 0, 1, 1);
        chk("illegal.err", 32'(err), 32'd1);
        tick();
        chk("illegal.err_sticky", 32'(err), 32'd1);
`else
        chk_all("illegal", 7, 2, 0, 1, 0);
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk_all("pend2", 7, c, int'(c == 6), int'(c < 3), 0);
        end
        tick();
        chk_all("wrap2", 2, 0, 0, 1, 1);
        for (int p = 1; p <= 6; p++) begin
            tick();
            chk_all("run2", 2, p % 2, int'((p % 2) == 1), int'((p % 2) == 0), 1);
        end
`endif

        // Enter PEND, then pulse rstb between clock edges.
        ratio_req = 8'd9;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("pend9.req_ready", 32'(req_ready), 32'd0);
        #1;
        rstb = 1'b0;
        #1;
        chk_all("async_rst", 16, 0, 0, 0, 1);
`ifdef FDIV_CTRL_ERR_EN
        chk("async_rst.err", 32'(err), 32'd0);
`endif
        en = 1'b0;
        tick();
        rstb = 1'b1;
        tick();
        chk_all("post_rst", 16, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
